// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the word-level 11011 scan controller and its detector.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REPORT
    } ctrl_state_t;

    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        S3,
        S4
    } det_state_t;

    localparam logic [4:0] PATTERN = 5'b11011;
    localparam int         PAT_LEN = 5;

    // Each state holds the longest matched prefix of PATTERN; a hit in S4 falls back to "11".
    function automatic det_state_t det_next(input det_state_t cur, input logic bit_in);
        det_state_t nxt;
        nxt = S0;
        case (cur)
            S0:      nxt = bit_in ? S1 : S0;
            S1:      nxt = bit_in ? S2 : S0;
            S2:      nxt = bit_in ? S2 : S3;
            S3:      nxt = bit_in ? S4 : S0;
            S4:      nxt = bit_in ? S2 : S0;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word-in / count-out handshake bundle between a producer/consumer and the scan controller.
interface seq_scan_ctrl_if #(
    parameter int WIDTH = 16
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_count
    );

endinterface

// File: rtl/seq_det_11011.sv
// Overlapping Mealy detector for the serial pattern 11011; advances only when en is high.
module seq_det_11011
    import seq_scan_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    det_state_t state;
    det_state_t state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    // clr and en never coincide in the controller; clr wins to keep word boundaries clean.
    always_comb begin
        state_next = state;
        hit        = 1'b0;
        if (clr) begin
            state_next = S0;
        end else if (en) begin
            state_next = det_next(state, bit_in);
            hit        = (state == S4) && bit_in;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts one word, shifts it MSB-first through the 11011 detector and reports the match count.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter bit CARRY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_scan_ctrl_if.slave        bus,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  hit,
    output logic                  busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    ctrl_state_t      state;
    ctrl_state_t      state_next;
    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             in_ready;
    logic             out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        bit_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                bit_valid = 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Count cannot exceed WIDTH/3+1, so the adder never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            idx   <= '0;
            count <= '0;
        end else if (accept) begin
            shreg <= bus.in_data;
            idx   <= '0;
            count <= '0;
        end else if (bit_valid) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            idx   <= idx + IDX_W'(1);
            count <= count + CNT_W'(hit);
        end
    end

    seq_det_11011 u_det (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept && !CARRY),
        .en     (bit_valid),
        .bit_in (bit_out),
        .hit    (hit)
    );

    assign bit_out       = shreg[WIDTH-1];
    assign busy          = (state != IDLE);
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_count = count;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: one CARRY=0 and one CARRY=1 instance sharing clock and reset.
module tb_seq_scan_ctrl;

    localparam int WIDTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl_if #(.WIDTH(WIDTH)) bus0 ();
    seq_scan_ctrl_if #(.WIDTH(WIDTH)) bus1 ();

    assign bus0.in_valid  = in_valid & ~sel;
    assign bus0.in_data   = in_data;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid & sel;
    assign bus1.in_data   = in_data;
    assign bus1.out_ready = out_ready;

    logic bit_out0, bit_valid0, hit0, busy0;
    logic bit_out1, bit_valid1, hit1, busy1;

    seq_scan_ctrl #(.WIDTH(WIDTH), .CARRY(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0),
        .bit_out   (bit_out0),
        .bit_valid (bit_valid0),
        .hit       (hit0),
        .busy      (busy0)
    );

    seq_scan_ctrl #(.WIDTH(WIDTH), .CARRY(1'b1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .bit_out   (bit_out1),
        .bit_valid (bit_valid1),
        .hit       (hit1),
        .busy      (busy1)
    );

    wire       obs_in_ready  = sel ? bus1.in_ready  : bus0.in_ready;
    wire       obs_out_valid = sel ? bus1.out_valid : bus0.out_valid;
    wire [4:0] obs_out_count = sel ? bus1.out_count : bus0.out_count;
    wire       obs_bit_out   = sel ? bit_out1   : bit_out0;
    wire       obs_bit_valid = sel ? bit_valid1 : bit_valid0;
    wire       obs_hit       = sel ? hit1       : hit0;
    wire       obs_busy      = sel ? busy1      : busy0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for in_ready, then presents one word across the accepting edge.
    task automatic applyStimulus(input logic [15:0] data);
        for (int i = 0; i < 40 && !obs_in_ready; i++) step();
        if (!obs_in_ready) checkOutput("in_ready_timeout", 64'(obs_in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = data;
        step();
        in_valid = 1'b0;
    endtask

    task automatic runWord(input string tag, input logic [15:0] data,
                           input logic [15:0] exp_mask, input logic [4:0] exp_count);
        logic [15:0] bits;
        logic [15:0] mask;
        logic        bv_ok;
        bits  = '0;
        mask  = '0;
        bv_ok = 1'b1;
        applyStimulus(data);
        for (int c = 0; c < WIDTH; c++) begin
            if (!obs_bit_valid) bv_ok = 1'b0;
            bits[15-c] = obs_bit_out;
            mask[c]    = obs_hit;
            step();
        end
        checkOutput({tag, "_bit_valid"}, 64'(bv_ok), 64'd1);
        checkOutput({tag, "_bits"}, 64'(bits), 64'(data));
        checkOutput({tag, "_hit_mask"}, 64'(mask), 64'(exp_mask));
        checkOutput({tag, "_out_valid"}, 64'(obs_out_valid), 64'd1);
        checkOutput({tag, "_out_count"}, 64'(obs_out_count), 64'(exp_count));
        checkOutput({tag, "_in_ready_rep"}, 64'(obs_in_ready), 64'd0);
        step();
        checkOutput({tag, "_out_valid_idle"}, 64'(obs_out_valid), 64'd0);
        checkOutput({tag, "_in_ready_idle"}, 64'(obs_in_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        checkOutput("rst_in_ready",  64'(obs_in_ready),  64'd1);
        checkOutput("rst_out_valid", 64'(obs_out_valid), 64'd0);
        checkOutput("rst_bit_valid", 64'(obs_bit_valid), 64'd0);
        checkOutput("rst_hit",       64'(obs_hit),       64'd0);
        checkOutput("rst_out_count", 64'(obs_out_count), 64'd0);
        checkOutput("rst_busy",      64'(obs_busy),      64'd0);

        runWord("d800", 16'hD800, 16'h0010, 5'd1);
        runWord("db6d", 16'hDB6D, 16'h2490, 5'd4);
        runWord("zero", 16'h0000, 16'h0000, 5'd0);
        runWord("ones", 16'hFFFF, 16'h0000, 5'd0);

        // 11|011 across a word boundary only matches when the detector carries.
        runWord("c0_w1", 16'h0003, 16'h0000, 5'd0);
        runWord("c0_w2", 16'h6000, 16'h0000, 5'd0);
        sel = 1'b1;
        step();
        runWord("c1_w1", 16'h0003, 16'h0000, 5'd0);
        runWord("c1_w2", 16'h6000, 16'h0004, 5'd1);
        runWord("c1_pre", 16'h0003, 16'h0000, 5'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        runWord("c1_after_rst", 16'h6000, 16'h0000, 5'd0);
        sel = 1'b0;
        step();

        // Back-pressure in REPORT with a new word waiting.
        out_ready = 1'b0;
        applyStimulus(16'hD800);
        repeat (WIDTH) step();
        in_valid = 1'b1;
        in_data  = 16'hDB6D;
        for (int h = 0; h < 5; h++) begin
            checkOutput("hold_out_valid", 64'(obs_out_valid), 64'd1);
            checkOutput("hold_out_count", 64'(obs_out_count), 64'd1);
            checkOutput("hold_in_ready",  64'(obs_in_ready),  64'd0);
            step();
        end
        out_ready = 1'b1;
        checkOutput("handoff_out_valid", 64'(obs_out_valid), 64'd1);
        checkOutput("handoff_in_ready",  64'(obs_in_ready),  64'd0);
        step();
        checkOutput("after_hold_in_ready",  64'(obs_in_ready),  64'd1);
        checkOutput("after_hold_out_valid", 64'(obs_out_valid), 64'd0);
        checkOutput("after_hold_busy",      64'(obs_busy),      64'd0);
        step();
        in_valid = 1'b0;
        checkOutput("queued_bit_valid", 64'(obs_bit_valid), 64'd1);
        repeat (WIDTH) step();
        checkOutput("queued_out_valid", 64'(obs_out_valid), 64'd1);
        checkOutput("queued_out_count", 64'(obs_out_count), 64'd4);
        step();

        // Reset during the 8th shift cycle abandons the word.
        applyStimulus(16'hD800);
        repeat (7) step();
        checkOutput("mid_bit_valid", 64'(obs_bit_valid), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("mid_rst_in_ready",  64'(obs_in_ready),  64'd1);
        checkOutput("mid_rst_out_valid", 64'(obs_out_valid), 64'd0);
        checkOutput("mid_rst_busy",      64'(obs_busy),      64'd0);
        checkOutput("mid_rst_bit_valid", 64'(obs_bit_valid), 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (obs_out_valid) seen = 1'b1;
                step();
            end
            checkOutput("mid_rst_no_result", 64'(seen), 64'd0);
        end
        runWord("post_rst", 16'hD800, 16'h0010, 5'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
